// File: rtl/timer_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : timer_ctrl_if
// Description : Register write bus feeding the timer control block.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface timer_ctrl_if;
   logic [31:0] wdata;
   logic        ctrl_wr;
   logic        tdr_lo_wr;
   logic        tdr_hi_wr;
   logic        cmp_lo_wr;
   logic        cmp_hi_wr;
   logic        int_clr_wr;

   modport master (
      output wdata, ctrl_wr, tdr_lo_wr, tdr_hi_wr, cmp_lo_wr, cmp_hi_wr, int_clr_wr
   );
   modport slave (
      input  wdata, ctrl_wr, tdr_lo_wr, tdr_hi_wr, cmp_lo_wr, cmp_hi_wr, int_clr_wr
   );
endinterface

`default_nettype wire

// File: rtl/timer_ctrl.sv
//------------------------------------------------------------------------------
// Module      : timer_ctrl
// Description : Control/sequencing for the 64-bit timer counter: shadowed TDR
//               and compare, prescaler setup, debug-halt handshake, match IRQ.
//               Optional macro PERIODIC_RELOAD_EN: reload counter on match.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_ctrl #(
   parameter int CNT_W = 64,
   parameter int DIV_W = 8
) (
   input  wire                sys_clk,
   input  wire                sys_rst_n,
   timer_ctrl_if.slave        bus,
   input  wire                dbg_mode,
   input  wire  [CNT_W-1:0]   cnt,
   output logic [CNT_W-1:0]   TDR,
   output logic               TDR_sel,
   output logic               timer_en,
   output logic               div_en,
   output logic [DIV_W-1:0]   clk_div,
   output logic               halt_req,
   output logic               halt_ack,
   output logic               int_st,
   output logic               tim_int
);

   localparam logic [1:0] S_RUN       = 2'd0;
   localparam logic [1:0] S_HALT_WAIT = 2'd1;
   localparam logic [1:0] S_HALTED    = 2'd2;

   logic               r_timer_en;
   logic               r_div_en;
   logic               r_int_en;
   logic               r_halt_en;
   logic [DIV_W-1:0]   r_clk_div;
   logic [31:0]        r_tdr_lo;
   logic [31:0]        r_cmp_lo;
   logic [CNT_W-1:0]   r_tdr;
   logic [CNT_W-1:0]   r_cmp;
   logic               r_tdr_sel;
   logic               r_match_d;
   logic               r_int_st;
   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               w_match_now;
   logic               w_match_rise;
   logic               w_halt_cond;
   logic               w_reload_pulse;
   logic [31:0]        w_tdr_lo_next;
   logic [31:0]        w_cmp_lo_next;

   assign w_match_now  = r_timer_en & (cnt == r_cmp);
   assign w_match_rise = w_match_now & ~r_match_d;
   assign w_halt_cond  = dbg_mode & r_halt_en & r_timer_en;

   // A same-cycle lo+hi write commits the fresh low word, not the old shadow.
   assign w_tdr_lo_next = bus.tdr_lo_wr ? bus.wdata : r_tdr_lo;
   assign w_cmp_lo_next = bus.cmp_lo_wr ? bus.wdata : r_cmp_lo;

`ifdef PERIODIC_RELOAD_EN
   logic r_auto_reload;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_auto_reload <= 1'b0;
      end else if (bus.ctrl_wr) begin
         r_auto_reload <= bus.wdata[4];
      end
   end

   assign w_reload_pulse = w_match_rise & r_auto_reload;
`else
   assign w_reload_pulse = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_timer_en <= 1'b0;
         r_div_en   <= 1'b0;
         r_int_en   <= 1'b0;
         r_halt_en  <= 1'b0;
         r_clk_div  <= '0;
      end else if (bus.ctrl_wr) begin
         r_timer_en <= bus.wdata[0];
         r_int_en   <= bus.wdata[2];
         r_halt_en  <= bus.wdata[3];
         // Prescaler setup is frozen while the timer runs.
         if (!r_timer_en) begin
            r_div_en  <= bus.wdata[1];
            r_clk_div <= bus.wdata[8 +: DIV_W];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_tdr_lo  <= '0;
         r_cmp_lo  <= '0;
         r_tdr     <= '0;
         r_cmp     <= '0;
         r_tdr_sel <= 1'b0;
      end else begin
         r_tdr_lo  <= w_tdr_lo_next;
         r_cmp_lo  <= w_cmp_lo_next;
         if (bus.tdr_hi_wr) begin
            r_tdr <= {bus.wdata, w_tdr_lo_next};
         end
         if (bus.cmp_hi_wr) begin
            r_cmp <= {bus.wdata, w_cmp_lo_next};
         end
         r_tdr_sel <= (bus.tdr_hi_wr & r_timer_en) | w_reload_pulse;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_match_d <= 1'b0;
         r_int_st  <= 1'b0;
      end else begin
         r_match_d <= w_match_now;
         if (w_match_rise) begin
            r_int_st <= 1'b1;
         end else if (bus.int_clr_wr && bus.wdata[0]) begin
            r_int_st <= 1'b0;
         end
      end
   end

   // HALT_WAIT lasts one cycle so a pending prescaler increment can land.
   always_comb begin
      w_state_nxt = S_RUN;
      case (r_state)
         S_RUN:       w_state_nxt = w_halt_cond ? S_HALT_WAIT : S_RUN;
         S_HALT_WAIT: w_state_nxt = w_halt_cond ? S_HALTED    : S_RUN;
         S_HALTED:    w_state_nxt = w_halt_cond ? S_HALTED    : S_RUN;
         default:     w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign TDR      = r_tdr;
   assign TDR_sel  = r_tdr_sel;
   assign timer_en = r_timer_en;
   assign div_en   = r_div_en;
   assign clk_div  = r_clk_div;
   assign halt_req = (r_state == S_HALT_WAIT) || (r_state == S_HALTED);
   assign halt_ack = (r_state == S_HALTED);
   assign int_st   = r_int_st;
   assign tim_int  = r_int_st & r_int_en;

endmodule

`default_nettype wire
